// File: rtl/cim_bitserial_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the bit-serial CIM sequencer.
package cim_pkg;

  localparam int CIM_ROWS   = 36;
  localparam int CIM_WBITS  = 8;
  localparam int CIM_PSUM_W = 14;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} cim_state_t;

  typedef logic [CIM_WBITS-1:0] cim_word_t;

  // Number of nodes entering a given level of a pairwise reduction tree.
  function automatic int tree_level_count(input int leaves, input int level);
    int n;
    n = leaves;
    for (int k = 0; k < level; k++) n = (n + 1) / 2;
    return n;
  endfunction

endpackage

// File: rtl/cim_bitserial_ctrl_if.sv
// Activation-in / result-out valid-ready channel of the CIM sequencer.
interface cim_bitserial_ctrl_if #(
  parameter int ROWS  = cim_pkg::CIM_ROWS,
  parameter int ABITS = 4,
  parameter int ACC_W = 18
);
  logic                    in_valid;
  logic                    in_ready;
  logic [ROWS*ABITS-1:0]   act;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        result;

  modport master (
    output in_valid, act, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, act, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/cim_bitserial_ctrl_psum_tree.sv
// Combinational balanced adder tree summing ROWS unsigned array products per bit-plane.
module cim_psum_tree
  import cim_pkg::*;
#(
  parameter int ROWS   = CIM_ROWS,
  parameter int WBITS  = CIM_WBITS,
  parameter int PSUM_W = CIM_PSUM_W
) (
  input  logic [ROWS*WBITS-1:0] prod,
  output logic [PSUM_W-1:0]     psum
);

  localparam int LEVELS = $clog2(ROWS);

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N_IN  = tree_level_count(ROWS, l);
    localparam int N_OUT = (N_IN + 1) / 2;

    logic [PSUM_W-1:0] src [N_IN];
    logic [PSUM_W-1:0] sum [N_OUT];

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N_IN; i++) begin : g_in
        assign src[i] = PSUM_W'(prod[i*WBITS +: WBITS]);
      end
    end else begin : g_link
      for (genvar i = 0; i < N_IN; i++) begin : g_in
        assign src[i] = g_lvl[l-1].sum[i];
      end
    end

    // An odd node at the end of a level passes straight through.
    for (genvar i = 0; i < N_OUT; i++) begin : g_node
      if (2*i + 1 < N_IN) begin : g_add
        assign sum[i] = src[2*i] + src[2*i+1];
      end else begin : g_pass
        assign sum[i] = src[2*i];
      end
    end
  end

  assign psum = g_lvl[LEVELS-1].sum[0];

endmodule

// File: rtl/cim_bitserial_ctrl.sv
// Bit-serial sequencer for the NOR compute-in-memory array: weight store, plane streaming, shift-accumulate.
// Build option CIM_SIGNED_ACT_EN: two's-complement activations (MSB plane subtracts).
//
// state   | meaning
// IDLE    | accepting weight writes and a new activation vector
// COMPUTE | driving one activation bit-plane per cycle, LSB first
// DONE    | result held until the consumer takes it
module cim_bitserial_ctrl
  import cim_pkg::*;
#(
  parameter int ROWS  = CIM_ROWS,
  parameter int WBITS = CIM_WBITS,
  parameter int ABITS = 4,
  parameter int ACC_W = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   w_we,
  input  logic [5:0]             w_addr,
  input  logic [WBITS-1:0]       w_data,
  cim_bitserial_ctrl_if.slave    bus,
  output logic                   busy,
  output logic [ROWS-1:0]        cim_a,
  output logic [ROWS*WBITS-1:0]  cim_w,
  input  logic [ROWS*WBITS-1:0]  cim_p
);

  localparam int PSUM_W  = $clog2(ROWS * ((1 << WBITS) - 1) + 1);
  localparam int PLANE_W = (ABITS > 1) ? $clog2(ABITS) : 1;
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(ABITS - 1);
  localparam logic [5:0]         ROW_LIMIT  = 6'(ROWS);

  cim_state_t            state, state_next;
  logic                  accept;
  logic                  last_plane;
  logic                  wr_en;
  logic [PLANE_W-1:0]    plane;
  logic [ROWS*ABITS-1:0] act_sr;
  logic [ACC_W-1:0]      acc, acc_next, shifted, result_q;
  logic [PSUM_W-1:0]     psum;
  cim_word_t             wreg [ROWS];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    accept        = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_plane) state_next = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign last_plane = (plane == LAST_PLANE);
  assign wr_en      = w_we && (state == IDLE) && (w_addr < ROW_LIMIT);
  assign shifted    = ACC_W'(psum) << plane;

`ifdef CIM_SIGNED_ACT_EN
  // The MSB plane of a two's-complement activation carries negative weight.
  assign acc_next = last_plane ? (acc - shifted) : (acc + shifted);
`else
  assign acc_next = acc + shifted;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) wreg[i] <= '0;
      act_sr   <= '0;
      acc      <= '0;
      plane    <= '0;
      result_q <= '0;
    end else begin
      if (wr_en) wreg[w_addr] <= w_data;
      if (accept) begin
        act_sr <= bus.act;
        acc    <= '0;
        plane  <= '0;
      end else if (state == COMPUTE) begin
        for (int i = 0; i < ROWS; i++)
          act_sr[i*ABITS +: ABITS] <= act_sr[i*ABITS +: ABITS] >> 1;
        acc   <= acc_next;
        plane <= plane + 1'b1;
        if (last_plane) result_q <= acc_next;
      end
    end
  end

  assign bus.result = result_q;

  // Array inputs are active-low; cim_a idles high so every product reads zero.
  for (genvar i = 0; i < ROWS; i++) begin : g_drive
    assign cim_w[i*WBITS +: WBITS] = ~wreg[i];
    assign cim_a[i] = (state == COMPUTE) ? ~act_sr[i*ABITS] : 1'b1;
  end

  cim_psum_tree #(
    .ROWS   (ROWS),
    .WBITS  (WBITS),
    .PSUM_W (PSUM_W)
  ) u_psum_tree (
    .prod (cim_p),
    .psum (psum)
  );

endmodule

// File: tb/tb_cim_bitserial_ctrl.sv
// Directed bench for cim_bitserial_ctrl with a behavioural NOR-array model on cim_a/cim_w/cim_p.
module tb_cim_bitserial_ctrl;

  localparam int ROWS  = 36;
  localparam int WBITS = 8;
  localparam int ABITS = 4;
  localparam int ACC_W = 18;

`ifdef CIM_SIGNED_ACT_EN
  localparam logic [ACC_W-1:0] EXP_MAX  = 18'd252964;  // 36*255*(-1)
  localparam logic [ACC_W-1:0] EXP_ROW5 = 18'd260744;  // 200*(-7)
`else
  localparam logic [ACC_W-1:0] EXP_MAX  = 18'd137700;
  localparam logic [ACC_W-1:0] EXP_ROW5 = 18'd1800;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  w_we;
  logic [5:0]            w_addr;
  logic [WBITS-1:0]      w_data;
  logic                  busy;
  logic [ROWS-1:0]       cim_a;
  logic [ROWS*WBITS-1:0] cim_w;
  logic [ROWS*WBITS-1:0] cim_p;

  int total = 0;
  int bad   = 0;
  int lat;
  logic [3:0] trace;
  logic       seen;
  logic [WBITS-1:0] wexp [ROWS];

  cim_bitserial_ctrl_if #(.ROWS(ROWS), .ABITS(ABITS), .ACC_W(ACC_W)) bus ();

  cim_bitserial_ctrl #(
    .ROWS(ROWS), .WBITS(WBITS), .ABITS(ABITS), .ACC_W(ACC_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_we   (w_we),
    .w_addr (w_addr),
    .w_data (w_data),
    .bus    (bus),
    .busy   (busy),
    .cim_a  (cim_a),
    .cim_w  (cim_w),
    .cim_p  (cim_p)
  );

  always #5 clk = ~clk;

  // NOR array: product = (activation bit) AND (weight), both inputs active-low.
  always_comb begin
    cim_p = '0;
    for (int i = 0; i < ROWS; i++)
      cim_p[i*WBITS +: WBITS] = cim_a[i] ? 8'h00 : ~cim_w[i*WBITS +: WBITS];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROWS*WBITS-1:0] exp_w();
    logic [ROWS*WBITS-1:0] v;
    for (int i = 0; i < ROWS; i++) v[i*WBITS +: WBITS] = ~wexp[i];
    return v;
  endfunction

  function automatic logic [ROWS*ABITS-1:0] act_all(input logic [3:0] val);
    logic [ROWS*ABITS-1:0] v;
    for (int i = 0; i < ROWS; i++) v[i*ABITS +: ABITS] = val;
    return v;
  endfunction

  function automatic logic [ROWS*ABITS-1:0] act_one(input int idx, input logic [3:0] val);
    logic [ROWS*ABITS-1:0] v;
    v = '0;
    v[idx*ABITS +: ABITS] = val;
    return v;
  endfunction

  task automatic write_w(input int addr, input logic [7:0] data);
    w_we   = 1'b1;
    w_addr = 6'(addr);
    w_data = data;
    tick();
    w_we = 1'b0;
    if (addr < ROWS) wexp[addr] = data;
  endtask

  task automatic run(input logic [ROWS*ABITS-1:0] a, input logic [ACC_W-1:0] exp_res,
                     input string tag, input bit hold, input bit wr_mid);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    bus.act      = a;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.act      = '0;
    chk({tag, "_busy"}, busy, 1);
    lat   = 1;
    trace = {cim_a[5], 3'b000};
    if (wr_mid) begin
      w_we   = 1'b1;
      w_addr = 6'd0;
      w_data = 8'd77;
    end
    while (!bus.out_valid && lat < 20) begin
      tick();
      w_we = 1'b0;
      lat++;
      if (lat <= ABITS) trace = {cim_a[5], trace[3:1]};
    end
    w_we = 1'b0;
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_out_valid"}, bus.out_valid, 1);
    chk({tag, "_result"}, bus.result, exp_res);
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        chk({tag, "_hold_valid"}, bus.out_valid, 1);
        chk({tag, "_hold_result"}, bus.result, exp_res);
        chk({tag, "_hold_in_ready"}, bus.in_ready, 0);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_post_in_ready"}, bus.in_ready, 1);
    chk({tag, "_post_out_valid"}, bus.out_valid, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    w_we          = 1'b0;
    w_addr        = '0;
    w_data        = '0;
    bus.in_valid  = 1'b0;
    bus.act       = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < ROWS; i++) wexp[i] = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_cim_a", cim_a, {ROWS{1'b1}});
    chk("rst_cim_w", cim_w, {(ROWS*WBITS){1'b1}});

    for (int i = 0; i < ROWS; i++) write_w(i, 8'd1);
    chk("unit_cim_w", cim_w, exp_w());
    run(act_all(4'd1), 18'd36, "unit", 1'b0, 1'b0);

    for (int i = 0; i < ROWS; i++) write_w(i, 8'd255);
    run(act_all(4'd15), EXP_MAX, "max", 1'b0, 1'b0);

    write_w(5, 8'd200);
    run(act_one(5, 4'd9), EXP_ROW5, "row5", 1'b1, 1'b0);
    chk("row5_plane_trace", trace, 4'b0110);

    write_w(0, 8'd3);
    run(act_one(0, 4'd1), 18'd3, "wr_busy_run", 1'b0, 1'b1);
    chk("wr_busy_cim_w", cim_w, exp_w());
    run(act_one(0, 4'd1), 18'd3, "wr_busy_next", 1'b0, 1'b0);

    write_w(40, 8'd99);
    write_w(36, 8'd99);
    chk("bad_addr_cim_w", cim_w, exp_w());

    bus.act      = act_one(2, 4'd6);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < ROWS; i++) wexp[i] = '0;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_cim_a", cim_a, {ROWS{1'b1}});
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_result", bus.result, 0);
    chk("midrst_cim_w", cim_w, exp_w());
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", seen, 0);
    write_w(2, 8'd17);
    run(act_one(2, 4'd6), 18'd102, "post_rst", 1'b0, 1'b0);

`ifdef CIM_SIGNED_ACT_EN
    write_w(0, 8'd10);
    run(act_one(0, 4'b1111), 18'd262134, "signed_neg", 1'b0, 1'b0);
    run(act_one(0, 4'b0111), 18'd70, "signed_pos", 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
